riscv_core_id_ex_pipe: RTL and testbench

Parametrised ID→EX pipeline stage with a valid/ready handshake, EX-driven stall (backpressure), synchronous flush and an optional two-entry skid buffer. It replaces the unconditional per-field ID output writes with a single packed payload register. The stage holds each decoded instruction bundle until EX consumes it. It also keeps the PC and instruction word of the last accepted instruction for trap/exception reporting.

---
 rtl/riscv_core_pipe_pkg.sv | 65 ++++++
 rtl/riscv_core_pipe_slot.sv | 42 ++++
 rtl/riscv_core_id_ex_pipe.sv | 102 ++++++++++
 tb/tb_riscv_core_id_ex_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_pipe_pkg.sv
// ID/EX payload layout shared by the decode side, the pipe stage and EX.
// Fields are packed MSB-first in the order listed in id_ex_t.
package riscv_core_pipe_pkg;

   localparam int ALUOP_W     = 4;
   localparam int ALUSRC1_W   = 2;
   localparam int ALUSRC2_W   = 1;
   localparam int BRANCHOP_W  = 3;
   localparam int BRNCH_SEL_W = 1;
   localparam int IMMED_W     = 32;
   localparam int MEMOP_W     = 4;
   localparam int RD_W        = 5;
   localparam int REG1_W      = 32;
   localparam int REG2_W      = 32;
   localparam int REGWRITE_W  = 1;
   localparam int RFWT_SEL_W  = 2;
   localparam int RS1_W       = 5;
   localparam int RS2_W       = 5;

   localparam int ID_EX_PAYLOAD_W = ALUOP_W + ALUSRC1_W + ALUSRC2_W + BRANCHOP_W +
                                    BRNCH_SEL_W + IMMED_W + MEMOP_W + RD_W + REG1_W +
                                    REG2_W + REGWRITE_W + RFWT_SEL_W + RS1_W + RS2_W;

   // Bit offsets of each field's LSB inside the packed payload
   localparam int RS2_OFS       = 0;
   localparam int RS1_OFS       = RS2_OFS + RS2_W;
   localparam int RFWT_SEL_OFS  = RS1_OFS + RS1_W;
   localparam int REGWRITE_OFS  = RFWT_SEL_OFS + RFWT_SEL_W;
   localparam int REG2_OFS      = REGWRITE_OFS + REGWRITE_W;
   localparam int REG1_OFS      = REG2_OFS + REG2_W;
   localparam int RD_OFS        = REG1_OFS + REG1_W;
   localparam int MEMOP_OFS     = RD_OFS + RD_W;
   localparam int IMMED_OFS     = MEMOP_OFS + MEMOP_W;
   localparam int BRNCH_SEL_OFS = IMMED_OFS + IMMED_W;
   localparam int BRANCHOP_OFS  = BRNCH_SEL_OFS + BRNCH_SEL_W;
   localparam int ALUSRC2_OFS   = BRANCHOP_OFS + BRANCHOP_W;
   localparam int ALUSRC1_OFS   = ALUSRC2_OFS + ALUSRC2_W;
   localparam int ALUOP_OFS     = ALUSRC1_OFS + ALUSRC1_W;

   typedef struct packed {
      logic [ALUOP_W-1:0]     aluop;
      logic [ALUSRC1_W-1:0]   alusrc1;
      logic [ALUSRC2_W-1:0]   alusrc2;
      logic [BRANCHOP_W-1:0]  branchop;
      logic [BRNCH_SEL_W-1:0] brnch_sel;
      logic [IMMED_W-1:0]     immed;
      logic [MEMOP_W-1:0]     memop;
      logic [RD_W-1:0]        rd;
      logic [REG1_W-1:0]      reg1;
      logic [REG2_W-1:0]      reg2;
      logic [REGWRITE_W-1:0]  regwrite;
      logic [RFWT_SEL_W-1:0]  rfwt_sel;
      logic [RS1_W-1:0]       rs1;
      logic [RS2_W-1:0]       rs2;
   } id_ex_t;

   function automatic logic [ID_EX_PAYLOAD_W-1:0] id_ex_pack(input id_ex_t f);
      return f;
   endfunction

   function automatic id_ex_t id_ex_unpack(input logic [ID_EX_PAYLOAD_W-1:0] v);
      return id_ex_t'(v);
   endfunction

endpackage

// File: rtl/riscv_core_pipe_slot.sv
// One pipeline entry {valid, payload, pc}. Clear drops only the valid bit;
// data holds its last value so the outputs never go X after the first load.
module riscv_core_pipe_slot
   import riscv_core_pipe_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int PAYLOAD_W = ID_EX_PAYLOAD_W
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 i_load,
   input  logic                 i_clr,
   input  logic [PAYLOAD_W-1:0] i_payload,
   input  logic [XLEN-1:0]      i_pc,
   output logic                 o_valid,
   output logic [PAYLOAD_W-1:0] o_payload,
   output logic [XLEN-1:0]      o_pc
);

   logic                 r_valid;
   logic [PAYLOAD_W-1:0] r_payload;
   logic [XLEN-1:0]      r_pc;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_valid   <= 1'b0;
         r_payload <= '0;
         r_pc      <= '0;
      end else if (i_clr) begin
         r_valid   <= 1'b0;
      end else if (i_load) begin
         r_valid   <= 1'b1;
         r_payload <= i_payload;
         r_pc      <= i_pc;
      end
   end

   assign o_valid   = r_valid;
   assign o_payload = r_payload;
   assign o_pc      = r_pc;

endmodule

// File: rtl/riscv_core_id_ex_pipe.sv
// ID->EX stage: valid/ready handshake, flush, trap PC/instr capture.
// Define RISCV_CORE_ID_EX_SKID_EN for a second (skid) entry and registered id_ready.
module riscv_core_id_ex_pipe
   import riscv_core_pipe_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int PAYLOAD_W = ID_EX_PAYLOAD_W
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 flush,
   input  logic                 id_valid,
   output logic                 id_ready,
   input  logic [PAYLOAD_W-1:0] id_payload,
   input  logic [XLEN-1:0]      id_pc,
   input  logic [31:0]          id_instr,
   output logic                 ex_valid,
   input  logic                 ex_ready,
   output logic [PAYLOAD_W-1:0] ex_payload,
   output logic [XLEN-1:0]      ex_pc,
   output logic [XLEN-1:0]      preserved_pc,
   output logic [31:0]          preserved_instr,
   output logic [1:0]           occupancy
);

   logic                 w_acc, w_cons;
   logic                 w_head_v, w_head_ld, w_head_clr;
   logic [PAYLOAD_W-1:0] w_head_d;
   logic [XLEN-1:0]      w_head_pc_d;
   logic                 w_skid_v;
   logic [XLEN-1:0]      r_pres_pc;
   logic [31:0]          r_pres_instr;

   assign w_acc  = id_valid & id_ready;
   assign w_cons = w_head_v & ex_ready;

`ifdef RISCV_CORE_ID_EX_SKID_EN
   logic                 w_skid_ld, w_skid_clr;
   logic [PAYLOAD_W-1:0] w_skid_payload;
   logic [XLEN-1:0]      w_skid_pc;

   // Depends only on slot state (and reset), never on ex_ready
   assign id_ready = !RST && !w_skid_v;

   // Head refills from skid first; id_ready is low whenever skid is valid,
   // so an accept and a skid->head move never coincide.
   assign w_head_ld   = !flush && (!w_head_v || w_cons) && (w_skid_v || w_acc);
   assign w_head_clr  = flush || (w_cons && !w_skid_v && !w_acc);
   assign w_head_d    = w_skid_v ? w_skid_payload : id_payload;
   assign w_head_pc_d = w_skid_v ? w_skid_pc : id_pc;
   assign w_skid_ld   = !flush && w_acc && w_head_v && !w_cons;
   assign w_skid_clr  = flush || (w_cons && w_skid_v);

   riscv_core_pipe_slot #(.XLEN(XLEN), .PAYLOAD_W(PAYLOAD_W)) u_skid (
      .CLK       (CLK),
      .RST       (RST),
      .i_load    (w_skid_ld),
      .i_clr     (w_skid_clr),
      .i_payload (id_payload),
      .i_pc      (id_pc),
      .o_valid   (w_skid_v),
      .o_payload (w_skid_payload),
      .o_pc      (w_skid_pc)
   );
`else
   assign id_ready    = !RST && (!w_head_v || ex_ready);
   assign w_head_ld   = !flush && w_acc;
   assign w_head_clr  = flush || (w_cons && !w_acc);
   assign w_head_d    = id_payload;
   assign w_head_pc_d = id_pc;
   assign w_skid_v    = 1'b0;
`endif

   riscv_core_pipe_slot #(.XLEN(XLEN), .PAYLOAD_W(PAYLOAD_W)) u_head (
      .CLK       (CLK),
      .RST       (RST),
      .i_load    (w_head_ld),
      .i_clr     (w_head_clr),
      .i_payload (w_head_d),
      .i_pc      (w_head_pc_d),
      .o_valid   (w_head_v),
      .o_payload (ex_payload),
      .o_pc      (ex_pc)
   );

   // A beat accepted under flush is dropped, so it must not become the trap PC
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pres_pc    <= '0;
         r_pres_instr <= '0;
      end else if (w_acc && !flush) begin
         r_pres_pc    <= id_pc;
         r_pres_instr <= id_instr;
      end
   end

   assign ex_valid        = w_head_v;
   assign preserved_pc    = r_pres_pc;
   assign preserved_instr = r_pres_instr;
   assign occupancy       = {1'b0, w_head_v} + {1'b0, w_skid_v};

endmodule

// File: tb/tb_riscv_core_id_ex_pipe.sv
// Directed-vector bench for riscv_core_id_ex_pipe; covers both skid and non-skid builds.
module tb_riscv_core_id_ex_pipe;

   localparam int XLEN = 32;
   localparam int PW   = 129;

   logic            CLK = 1'b0;
   logic            RST;
   logic            flush, id_valid, ex_ready;
   logic            id_ready, ex_valid;
   logic [PW-1:0]   id_payload, ex_payload;
   logic [XLEN-1:0] id_pc, ex_pc, preserved_pc;
   logic [31:0]     id_instr, preserved_instr;
   logic [1:0]      occupancy;

   int total = 0;
   int bad   = 0;

   riscv_core_id_ex_pipe #(.XLEN(XLEN), .PAYLOAD_W(PW)) dut (
      .CLK             (CLK),
      .RST             (RST),
      .flush           (flush),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_payload      (id_payload),
      .id_pc           (id_pc),
      .id_instr        (id_instr),
      .ex_valid        (ex_valid),
      .ex_ready        (ex_ready),
      .ex_payload      (ex_payload),
      .ex_pc           (ex_pc),
      .preserved_pc    (preserved_pc),
      .preserved_instr (preserved_instr),
      .occupancy       (occupancy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [PW-1:0] p, input logic [XLEN-1:0] pc,
                        input logic [31:0] ins);
      id_valid   = v;
      id_payload = p;
      id_pc      = pc;
      id_instr   = ins;
   endtask

   logic [PW-1:0] pa, pb, pc_;

   initial begin
      pa  = {1'b1, 64'hA5A5_0000_1111_2222, 64'h0000_0000_0000_00AA};
      pb  = {1'b0, 64'h5A5A_FFFF_EEEE_DDDD, 64'h0000_0000_0000_00BB};
      pc_ = {1'b1, 64'hCCCC_CCCC_CCCC_CCCC, 64'h0000_0000_0000_00CC};
      RST = 1'b1; flush = 1'b0; ex_ready = 1'b0;
      drive(1'b0, '0, '0, '0);

      // reset state
      #3;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_id_ready", id_ready, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_payload", ex_payload, 0);
      chk("rst_pres_pc", preserved_pc, 0);
      step();
      RST = 1'b0;
      #1;
      chk("post_rst_id_ready", id_ready, 1);

      // streaming, one beat per cycle, accept+consume at occupancy 1
      ex_ready = 1'b1;
      drive(1'b1, 129'd1, 32'h100, 32'h0000_00A1);
      step();
      chk("s1_valid", ex_valid, 1);
      chk("s1_payload", ex_payload, 1);
      chk("s1_pc", ex_pc, 32'h100);
      drive(1'b1, 129'd2, 32'h104, 32'h0000_00A2);
      step();
      chk("s2_payload", ex_payload, 2);
      chk("s2_occ", occupancy, 1);
      chk("s2_id_ready", id_ready, 1);
      drive(1'b1, 129'd3, 32'h108, 32'h0000_00A3);
      step();
      chk("s3_payload", ex_payload, 3);
      chk("s3_pres_pc", preserved_pc, 32'h108);
      chk("s3_pres_instr", preserved_instr, 32'h0000_00A3);
      drive(1'b0, '0, 32'h0, 32'h0);
      step();
      chk("drain_valid", ex_valid, 0);
      chk("drain_occ", occupancy, 0);

`ifdef RISCV_CORE_ID_EX_SKID_EN
      // stall builds the skid entry
      ex_ready = 1'b0;
      drive(1'b1, pa, 32'h200, 32'h0000_0B01);
      step();
      chk("sk_a_payload", ex_payload, pa);
      chk("sk_a_id_ready", id_ready, 1);
      drive(1'b1, pb, 32'h204, 32'h0000_0B02);
      step();
      chk("sk_full_occ", occupancy, 2);
      chk("sk_full_id_ready", id_ready, 0);
      chk("sk_full_head", ex_payload, pa);
      ex_ready = 1'b1;
      #1;
      chk("sk_no_comb_ready", id_ready, 0);
      drive(1'b0, '0, 32'h0, 32'h0);
      step();
      chk("sk_b_payload", ex_payload, pb);
      chk("sk_b_pc", ex_pc, 32'h204);
      chk("sk_b_occ", occupancy, 1);
      step();
      chk("sk_empty", ex_valid, 0);

      // flush with full skid, C presented
      ex_ready = 1'b0;
      drive(1'b1, pa, 32'h200, 32'h0000_0B01);
      step();
      drive(1'b1, pb, 32'h204, 32'h0000_0B02);
      step();
      chk("fl_pre_occ", occupancy, 2);
      flush = 1'b1;
      drive(1'b1, pc_, 32'h300, 32'h0000_0C03);
      step();
      flush = 1'b0;
      drive(1'b0, '0, 32'h0, 32'h0);
      chk("fl_valid", ex_valid, 0);
      chk("fl_occ", occupancy, 0);
      chk("fl_pres_pc", preserved_pc, 32'h204);
      step();
      chk("fl_c_absent", ex_valid, 0);

      // build occupancy 2 for the async reset check
      drive(1'b1, pa, 32'h400, 32'h0000_0D04);
      step();
      drive(1'b1, pb, 32'h404, 32'h0000_0D05);
      step();
      chk("ar_pre_occ", occupancy, 2);
`else
      // stall without skid: ready drops combinationally
      ex_ready = 1'b0;
      drive(1'b1, pa, 32'h200, 32'h0000_0B01);
      step();
      chk("ns_a_payload", ex_payload, pa);
      chk("ns_stall_id_ready", id_ready, 0);
      drive(1'b1, pb, 32'h204, 32'h0000_0B02);
      step();
      chk("ns_hold_payload", ex_payload, pa);
      chk("ns_hold_occ", occupancy, 1);
      chk("ns_hold_pres_pc", preserved_pc, 32'h200);
      ex_ready = 1'b1;
      #1;
      chk("ns_comb_ready", id_ready, 1);
      step();
      chk("ns_b_payload", ex_payload, pb);
      chk("ns_b_pc", ex_pc, 32'h204);
      chk("ns_b_occ", occupancy, 1);
      drive(1'b0, '0, 32'h0, 32'h0);
      step();
      chk("ns_empty", ex_valid, 0);

      // flush while a beat is accepted in the same cycle
      ex_ready = 1'b0;
      drive(1'b1, pc_, 32'h300, 32'h0000_0C03);
      step();
      ex_ready = 1'b1;
      flush = 1'b1;
      drive(1'b1, pa, 32'h310, 32'h0000_0C04);
      #1;
      chk("fl_id_ready", id_ready, 1);
      step();
      flush = 1'b0;
      drive(1'b0, '0, 32'h0, 32'h0);
      chk("fl_valid", ex_valid, 0);
      chk("fl_occ", occupancy, 0);
      chk("fl_pres_pc", preserved_pc, 32'h300);

      // head full for the async reset check
      ex_ready = 1'b0;
      drive(1'b1, pb, 32'h400, 32'h0000_0D04);
      step();
      chk("ar_pre_occ", occupancy, 1);
`endif

      // async reset between edges
      #2;
      RST = 1'b1;
      #1;
      chk("ar_valid", ex_valid, 0);
      chk("ar_occ", occupancy, 0);
      chk("ar_pres_pc", preserved_pc, 0);
      chk("ar_pres_instr", preserved_instr, 0);
      chk("ar_id_ready", id_ready, 0);
      drive(1'b0, '0, 32'h0, 32'h0);
      step();
      RST = 1'b0;
      step();
      chk("ar_after_valid", ex_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
